// File: rtl/mem_stage.sv
// Memory-access stage: latency-configurable data RAM with RV32I byte/half/word
// loads and stores, load extension and writeback result select.
module mem_stage #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [DATA_WIDTH-1:0] PCPlus4,
    input  logic [2:0]            funct3,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            ResultSrc,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  stall,
    output logic                  misaligned
);
    localparam int unsigned IW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam int unsigned NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic                  mem_op, aligned, accept, in_done;
    logic [IW-1:0]         widx;
    logic [1:0]            boff;
    logic [DATA_WIDTH-1:0] rd_word, rd_shift, load_data, st_data;
    logic [NB-1:0]         st_be;
    logic                  unused_addr;

    assign widx        = ALUResult[IW+1:2];
    assign boff        = ALUResult[1:0];
    assign unused_addr = ^ALUResult[DATA_WIDTH-1:IW+2];

    always_comb begin
        case (funct3)
            3'b001, 3'b101: aligned = ~boff[0];
            3'b010:         aligned = (boff == 2'b00);
            default:        aligned = 1'b1;
        endcase
    end

    assign mem_op     = valid_i & (MemRead | MemWrite);
    assign accept     = ~rst & (state_q == S_IDLE) & mem_op & aligned;
    assign stall      = ~rst & (accept | (state_q == S_WAIT));
    assign misaligned = ~rst & (state_q == S_IDLE) & mem_op & ~aligned;
    // Inputs are held through the access, so DONE reuses the live address/data.
    assign in_done    = ~rst & (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (LATENCY == 1) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CW'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_word  = mem_q[widx];
    assign rd_shift = rd_word >> {boff, 3'b000};

    always_comb begin
        load_data = '0;
        if (in_done && MemRead) begin
            case (funct3)
                3'b000:  load_data = {{(DATA_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
                3'b001:  load_data = {{(DATA_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
                3'b010:  load_data = rd_word;
                3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, rd_shift[7:0]};
                3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, rd_shift[15:0]};
                default: load_data = '0;
            endcase
        end
    end

    // Narrow store data is replicated across lanes; byte enables pick the target.
    always_comb begin
        st_be   = '0;
        st_data = WriteData;
        case (funct3)
            3'b000: begin
                st_be   = NB'(1) << boff;
                st_data = {NB{WriteData[7:0]}};
            end
            3'b001: begin
                st_be   = NB'(3) << boff;
                st_data = {(NB/2){WriteData[15:0]}};
            end
            3'b010:  st_be = '1;
            default: st_be = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_done && MemWrite) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (st_be[b]) mem_q[widx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        case (ResultSrc)
            2'b00:   Result = ALUResult;
            2'b01:   Result = load_data;
            2'b10:   Result = PCPlus4;
            default: Result = '0;
        endcase
    end
endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage against a byte-addressed reference memory.
module tb_mem_stage;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst, valid_i, MemRead, MemWrite, stall, misaligned;
    logic [31:0] ALUResult, WriteData, PCPlus4, Result;
    logic [2:0]  funct3;
    logic [1:0]  ResultSrc;

    int n_vec = 0;
    int n_err = 0;
    bit [7:0] rmem [4096];

    always #5 clk = ~clk;

    mem_stage #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ALUResult(ALUResult),
        .WriteData(WriteData), .PCPlus4(PCPlus4), .funct3(funct3),
        .MemRead(MemRead), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
        .Result(Result), .stall(stall), .misaligned(misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_aligned(input logic [2:0] f, input logic [31:0] a);
        if (f == 3'b001 || f == 3'b101) return a % 2 == 0;
        if (f == 3'b010) return a % 4 == 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a);
        int unsigned b = a % 4096;
        int signed   v;
        case (f)
            3'b000: begin v = int'(rmem[b]); if (v >= 128) v -= 256; return v; end
            3'b100: return rmem[b];
            3'b001: begin v = rmem[b] + 256 * rmem[b+1]; if (v >= 32768) v -= 65536; return v; end
            3'b101: return rmem[b] + 256 * rmem[b+1];
            3'b010: return {rmem[b+3], rmem[b+2], rmem[b+1], rmem[b]};
            default: return 0;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        int unsigned b = a % 4096;
        int unsigned n = (f == 3'b000) ? 1 : (f == 3'b001) ? 2 : 4;
        for (int unsigned i = 0; i < n; i++) rmem[b+i] = 8'((d >> (8*i)) & 32'hFF);
    endtask

    function automatic logic [31:0] ref_mux(input logic [1:0] rs, input logic [31:0] a,
                                            input logic [31:0] ld, input logic [31:0] pc);
        case (rs)
            2'b00:   return a;
            2'b01:   return ld;
            2'b10:   return pc;
            default: return 0;
        endcase
    endfunction

    task automatic drive(input bit v, input bit mr, input bit mw, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [1:0] rs);
        valid_i = v; MemRead = mr; MemWrite = mw; funct3 = f;
        ALUResult = a; WriteData = wd; PCPlus4 = pc; ResultSrc = rs;
    endtask

    task automatic do_op(input string tag, input bit v, input bit mr, input bit mw,
                         input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [1:0] rs);
        bit acc, mis;
        int k;
        logic [31:0] ld;
        @(posedge clk); #1;
        drive(v, mr, mw, f, a, wd, pc, rs);
        acc = v && (mr || mw) && is_aligned(f, a);
        mis = v && (mr || mw) && !is_aligned(f, a);
        #1;
        chk({tag, ":stall0"}, {31'b0, stall}, {31'b0, acc});
        chk({tag, ":mis0"}, {31'b0, misaligned}, {31'b0, mis});
        chk({tag, ":res0"}, Result, ref_mux(rs, a, 32'h0, pc));
        if (acc) begin
            k = 0;
            while (stall === 1'b1 && k < 4*LAT + 4) begin
                @(posedge clk); #1;
                k++;
            end
            chk({tag, ":lat"}, k, LAT);
            ld = mr ? ref_load(f, a) : 32'h0;
            chk({tag, ":res"}, Result, ref_mux(rs, a, ld, pc));
            chk({tag, ":misD"}, {31'b0, misaligned}, 32'h0);
            if (mw) ref_store(f, a, wd);
        end
    endtask

    initial begin
        logic [2:0]  f;
        logic [1:0]  rs;
        logic [31:0] a;
        bit          v;
        int          t;
        logic [2:0]  ld_f [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [1:0]  st_rs [3] = '{2'b00, 2'b10, 2'b11};

        rst = 1'b1;
        drive(1, 1, 0, 3'b010, 32'h0, 32'h0, 32'h0, 2'b01);
        repeat (3) @(posedge clk);
        #1;
        chk("rst:stall", {31'b0, stall}, 32'h0);
        chk("rst:res", Result, 32'h0);
        ALUResult = 32'h2; #1;
        chk("rst:mis", {31'b0, misaligned}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        valid_i = 1'b0;

        for (int unsigned w = 0; w < 1024; w++)
            do_op("pre", 1, 0, 1, 3'b010, w * 4, $urandom, 32'h0, 2'b00);

        do_op("t1sw", 1, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 2'b00);
        do_op("t1lw", 1, 1, 0, 3'b010, 32'h10, 32'h0, 32'h0, 2'b01);
        do_op("t2sw", 1, 0, 1, 3'b010, 32'h10, 32'h11223344, 32'h0, 2'b00);
        do_op("t2sb", 1, 0, 1, 3'b000, 32'h13, 32'h80, 32'h0, 2'b00);
        do_op("t2lb", 1, 1, 0, 3'b000, 32'h13, 32'h0, 32'h0, 2'b01);
        do_op("t2lbu", 1, 1, 0, 3'b100, 32'h13, 32'h0, 32'h0, 2'b01);
        do_op("t2lw", 1, 1, 0, 3'b010, 32'h10, 32'h0, 32'h0, 2'b01);
        do_op("t3lh", 1, 1, 0, 3'b001, 32'h11, 32'h0, 32'h0, 2'b01);
        do_op("t3lw", 1, 1, 0, 3'b010, 32'h10, 32'h0, 32'h0, 2'b01);
        do_op("t4pc", 1, 0, 0, 3'b000, 32'h0, 32'h0, 32'h104, 2'b10);
        do_op("t4alu", 1, 0, 0, 3'b000, 32'h7, 32'h0, 32'h104, 2'b00);

        @(posedge clk); #1;
        drive(1, 0, 1, 3'b010, 32'h20, 32'h55, 32'h0, 2'b00);
        #1 chk("t5:acc", {31'b0, stall}, 32'h1);
        @(posedge clk); #1;
        chk("t5:wait", {31'b0, stall}, 32'h1);
        rst = 1'b1; #1;
        chk("t5:rststall", {31'b0, stall}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; valid_i = 1'b0; #1;
        chk("t5:idle", {31'b0, stall}, 32'h0);
        do_op("t5lw", 1, 1, 0, 3'b010, 32'h20, 32'h0, 32'h0, 2'b01);

        @(posedge clk); #1;
        drive(1, 0, 1, 3'b010, 32'h24, 32'h77, 32'h0, 2'b00);
        repeat (LAT) @(posedge clk);
        #1 chk("t5b:done", {31'b0, stall}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; valid_i = 1'b0;
        do_op("t5blw", 1, 1, 0, 3'b010, 32'h24, 32'h0, 32'h0, 2'b01);

        do_op("t6sw", 1, 0, 1, 3'b010, 32'h1000, 32'hA5, 32'h0, 2'b00);
        do_op("t6lw", 1, 1, 0, 3'b010, 32'h0, 32'h0, 32'h0, 2'b01);
        chk("t6:val", Result, 32'hA5);

        repeat (400) begin
            t = $urandom_range(0, 9);
            a = $urandom_range(0, 32'h3FFF);
            v = ($urandom_range(0, 7) != 0);
            if (t < 4) begin
                if ($urandom_range(0, 9) == 0) begin
                    f = 3'($urandom_range(6, 8) == 8 ? 3 : $urandom_range(6, 7));
                    a = a & ~32'h3;
                end else begin
                    f = ld_f[$urandom_range(0, 4)];
                end
                rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
                do_op("rld", v, 1, 0, f, a, $urandom, $urandom, rs);
            end else if (t < 7) begin
                f = ld_f[$urandom_range(0, 2)];
                do_op("rst", v, 0, 1, f, a, $urandom, $urandom, st_rs[$urandom_range(0, 2)]);
            end else begin
                do_op("rmisc", v, 0, 0, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                      2'($urandom_range(0, 3)));
            end
        end

        @(posedge clk); #1;
        valid_i = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
